// File: rtl/pipe_latch_skid.sv
`timescale 1ns/1ps
// Two-entry pipeline latch: MAIN drives the outputs, SKID catches one entry while downstream stalls.
// One-cycle latency, one entry/cycle; in_ready comes from registered state only, so out_ready never reaches it.
module pipe_latch_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t           state;
  entry_t           mainQ;
  entry_t           skidQ;
  entry_t           inEntry;
  logic [CNT_W-1:0] stallCnt;
  logic             inFire;
  logic             outFire;

  assign inEntry = {in_ctrl, in_data};
  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      mainQ    <= '0;
      skidQ    <= '0;
      stallCnt <= '0;
    end else begin
      // Performance counter survives flush; only reset clears it.
      if (out_valid && !out_ready && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};

      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (inFire) begin
              mainQ <= inEntry;
              state <= ONE;
            end
          end
          ONE: begin
            if (inFire && outFire) begin
              mainQ <= inEntry;
            end else if (inFire) begin
              skidQ <= inEntry;
              state <= TWO;
            end else if (outFire) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (outFire) begin
              mainQ <= skidQ;
              state <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = mainQ.data;
  // Side-effect controls are masked on bubbles so a stale MAIN cannot retrigger them.
  assign out_ctrl  = out_valid ? mainQ.ctrl : '0;
  assign occupancy = state;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_latch_skid.sv
`timescale 1ns/1ps
// Directed bench for pipe_latch_skid: default instance plus a CNT_W=4 instance sharing the same stimulus.
module tb_pipe_latch_skid;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [15:0] inData;
  logic [3:0]  inCtrl;
  logic        flush;
  logic        outReady;

  logic        inReady, outValid;
  logic [15:0] outData;
  logic [3:0]  outCtrl;
  logic [1:0]  occupancy;
  logic [15:0] stallCnt;

  logic        inReady4, outValid4;
  logic [15:0] outData4;
  logic [3:0]  outCtrl4;
  logic [1:0]  occupancy4;
  logic [3:0]  stallCnt4;

  int checks = 0;
  int errors = 0;

  pipe_latch_skid dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl),
    .flush(flush),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ctrl(outCtrl),
    .occupancy(occupancy), .stall_cnt(stallCnt)
  );

  pipe_latch_skid #(.DATA_W(16), .CTRL_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady4), .in_data(inData), .in_ctrl(inCtrl),
    .flush(flush),
    .out_valid(outValid4), .out_ready(outReady), .out_data(outData4), .out_ctrl(outCtrl4),
    .occupancy(occupancy4), .stall_cnt(stallCnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = '0; inCtrl = '0; flush = 1'b0; outReady = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", outValid, 0);
    chk("rst_in_ready", inReady, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_data", outData, 0);
    chk("rst_out_ctrl", outCtrl, 0);
    chk("rst_stall_cnt", stallCnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..8 with 1-cycle latency
    outReady = 1'b1; inValid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      inData = 16'(i);
      tick();
      chk($sformatf("stream_data_%0d", i), outData, i);
      chk($sformatf("stream_occ_%0d", i), occupancy, 1);
    end
    inValid = 1'b0;
    tick();
    chk("stream_drain_valid", outValid, 0);
    chk("stream_drain_data_hold", outData, 16'h0008);
    chk("stream_stall_cnt", stallCnt, 0);

    // Back-pressure: A, B then stall
    outReady = 1'b0; inValid = 1'b1; inData = 16'h000A;
    tick();
    chk("bp_a_occ", occupancy, 1);
    inData = 16'h000B;
    tick();
    chk("bp_b_occ", occupancy, 2);
    inValid = 1'b0;
    tick();
    tick();
    chk("bp_occ2", occupancy, 2);
    chk("bp_in_ready", inReady, 0);
    chk("bp_hold_a", outData, 16'h000A);
    chk("bp_stall3", stallCnt, 3);
    outReady = 1'b1;
    #1;
    chk("bp_in_ready_no_comb", inReady, 0);
    chk("bp_release_a", outData, 16'h000A);
    tick();
    chk("bp_release_b", outData, 16'h000B);
    chk("bp_release_occ1", occupancy, 1);
    chk("bp_release_stall", stallCnt, 3);
    tick();
    chk("bp_empty_occ", occupancy, 0);
    chk("bp_empty_valid", outValid, 0);

    // Flush while TWO with 0xC presented
    outReady = 1'b0; inValid = 1'b1; inData = 16'h0001; inCtrl = 4'h3;
    tick();
    inData = 16'h0002;
    tick();
    chk("fl_two_occ", occupancy, 2);
    flush = 1'b1; inData = 16'h000C; inCtrl = 4'h0;
    tick();
    flush = 1'b0; inValid = 1'b0;
    chk("fl_valid", outValid, 0);
    chk("fl_ctrl", outCtrl, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_stall_kept", stallCnt, 5);
    tick();
    chk("fl_c_never", outValid, 0);

    // Flush while ONE: in_ready high, fired entry still discarded
    inValid = 1'b1; inData = 16'h0011;
    tick();
    flush = 1'b1; inData = 16'h000C;
    #1;
    chk("fl1_in_ready", inReady, 1);
    tick();
    flush = 1'b0; inValid = 1'b0;
    tick();
    chk("fl1_valid", outValid, 0);
    chk("fl1_data_hold", outData, 16'h0011);
    chk("fl1_stall", stallCnt, 6);

    // Bubble gating of control bits
    outReady = 1'b1; inValid = 1'b1; inData = 16'h0055; inCtrl = 4'b0010;
    tick();
    chk("bub_valid", outValid, 1);
    chk("bub_ctrl", outCtrl, 4'b0010);
    inValid = 1'b0; inCtrl = 4'b0000;
    tick();
    chk("bub_ctrl_zero", outCtrl, 4'b0000);
    chk("bub_valid_zero", outValid, 0);
    chk("bub_data_hold", outData, 16'h0055);

    // Asynchronous reset mid-TWO
    outReady = 1'b0; inValid = 1'b1; inData = 16'h0021; inCtrl = 4'h1;
    tick();
    inData = 16'h0022;
    tick();
    inValid = 1'b0;
    chk("ar_two_occ", occupancy, 2);
    chk("ar_two_stall", stallCnt, 7);
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", outValid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_stall", stallCnt, 0);
    chk("ar_in_ready", inReady, 1);
    chk("ar_data", outData, 0);
    #2 rst = 1'b0;
    inValid = 1'b1; inData = 16'h0077; inCtrl = 4'h0; outReady = 1'b1;
    tick();
    chk("ar_accept_valid", outValid, 1);
    chk("ar_accept_data", outData, 16'h0077);
    chk("ar_accept_occ", occupancy, 1);

    // Saturation of the 4-bit counter
    inValid = 1'b0; outReady = 1'b0;
    repeat (20) tick();
    chk("sat4_15", stallCnt4, 15);
    chk("sat16_20", stallCnt, 20);
    chk("sat4_occ", occupancy4, 1);
    repeat (3) tick();
    chk("sat4_stays", stallCnt4, 15);
    chk("sat16_23", stallCnt, 23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
